parking_gate_ctrl: RTL and testbench

- Downstream consumer of the parking-lot occupancy counter. Takes its completed-event code (dtc) and occupancy count (cnt) as inputs.
- Drives the entry barrier through a request/open/hold/close state machine with a timeout, gated by a capacity-full check.
- Raises sticky error flags for tailgating, count overflow and count underflow.
- Sits between the occupancy counter and the barrier actuator / lot-status lamps.

---
 rtl/parking_gate_ctrl_pkg.sv | 38 +++
 rtl/parking_gate_ctrl_gate_timer.sv | 47 ++++
 rtl/parking_gate_ctrl.sv | 159 +++++++++++++++
 tb/tb_parking_gate_ctrl.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/parking_gate_ctrl_pkg.sv
// parking_gate_ctrl_pkg
// Shared definitions for the parking-lot entry gate controller:
//   - gate FSM state encoding
//   - event codes coming from the occupancy counter (dtc)
//   - bit positions inside the sticky error-flag vector
//   - helper for sizing the gate timer
package parking_gate_ctrl_pkg;

  // Gate FSM states. The encoding is fixed because the lot-status logic
  // downstream may probe it directly.
  typedef enum logic [1:0] {
    CLOSED = 2'b00,
    OPEN   = 2'b01,
    HOLD   = 2'b10
  } gate_state_e;

  // Event codes from the occupancy counter. Code 2'b10 is reserved and is
  // treated as "no event".
  localparam logic [1:0] DTC_NONE  = 2'b00;
  localparam logic [1:0] DTC_ENTRY = 2'b01;
  localparam logic [1:0] DTC_EXIT  = 2'b11;

  // Bit positions in err_flags = {tailgate, overflow, underflow}.
  localparam int TAILGATE  = 2;
  localparam int OVERFLOW  = 1;
  localparam int UNDERFLOW = 0;

  // Timer width: enough bits for the larger of the two reload values,
  // never less than one bit so a degenerate 1-cycle setting still builds.
  function automatic int timer_width(input int open_timeout, input int close_delay);
    int biggest;
    int w;
    biggest = (open_timeout > close_delay) ? open_timeout : close_delay;
    w = $clog2(biggest);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/parking_gate_ctrl_gate_timer.sv
// gate_timer
// Loadable down-counter used by the gate FSM for both the open-timeout and
// the close-delay intervals.
// Ports:
//   clk    in  system clock, rising edge
//   rst    in  synchronous active-high reset (count -> 0)
//   load   in  load 'value' this cycle (has priority over dec)
//   value  in  [W-1:0] reload value
//   dec    in  decrement request; ignored when the count is already zero
//   zero   out count is zero
module gate_timer #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] value,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: a load wins over a decrement, and the counter saturates at
  // zero instead of wrapping so a stray dec can never re-arm it.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = value;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/parking_gate_ctrl.sv
// parking_gate_ctrl
// Entry-barrier controller sitting behind the parking-lot occupancy counter.
// Opens the barrier on a ticket request when the lot is not full, closes it
// after an entry (with a hold delay) or after a timeout, and keeps sticky
// error flags for tailgating and counter overflow/underflow.
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   req_in     in   entry request (ticket button), level
//   dtc        in   [1:0] counter event: 00 none, 01 entry, 11 exit, 10 reserved
//   cnt        in   [2:0] current occupancy
//   err_clr    in   clears err_flags
//   gate_open  out  barrier open command
//   full       out  registered lot-full indicator
//   deny       out  one-cycle pulse per refused request cycle (lot full)
//   timeout    out  one-cycle pulse when the gate closes without an entry
//   err_flags  out  [2:0] sticky {tailgate, overflow, underflow}
module parking_gate_ctrl
  import parking_gate_ctrl_pkg::*;
#(
  parameter int CAPACITY     = 7,
  parameter int OPEN_TIMEOUT = 1000,
  parameter int CLOSE_DELAY  = 200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_in,
  input  logic [1:0] dtc,
  input  logic [2:0] cnt,
  input  logic       err_clr,
  output logic       gate_open,
  output logic       full,
  output logic       deny,
  output logic       timeout,
  output logic [2:0] err_flags
);

  localparam int TW = timer_width(OPEN_TIMEOUT, CLOSE_DELAY);
  localparam logic [TW-1:0] OPEN_RELOAD  = TW'(OPEN_TIMEOUT - 1);
  localparam logic [TW-1:0] CLOSE_RELOAD = TW'(CLOSE_DELAY - 1);

  gate_state_e state_q, state_d;
  logic        gate_open_q, gate_open_d;
  logic        full_q, full_d;
  logic        deny_q, deny_d;
  logic        timeout_q, timeout_d;
  logic [2:0]  err_q, err_d;
  logic [2:0]  err_new;

  logic          t_load;
  logic [TW-1:0] t_value;
  logic          t_dec;
  logic          t_zero;

  logic is_entry;
  logic is_exit;

  assign is_entry = (dtc == DTC_ENTRY);
  assign is_exit  = (dtc == DTC_EXIT);

  gate_timer #(.W(TW)) u_timer (
    .clk   (clk),
    .rst   (rst),
    .load  (t_load),
    .value (t_value),
    .dec   (t_dec),
    .zero  (t_zero)
  );

  // Gate FSM next state, timer control and output pulses. All decisions use
  // the registered full flag, so a count change takes one cycle to matter.
  // In OPEN an entry beats the timeout even on the cycle the timer is zero.
  always_comb begin
    state_d   = state_q;
    t_load    = 1'b0;
    t_value   = '0;
    t_dec     = 1'b0;
    deny_d    = 1'b0;
    timeout_d = 1'b0;
    unique case (state_q)
      CLOSED: begin
        if (req_in) begin
          if (!full_q) begin
            state_d = OPEN;
            t_load  = 1'b1;
            t_value = OPEN_RELOAD;
          end else begin
            deny_d = 1'b1;
          end
        end
      end
      OPEN: begin
        if (is_entry) begin
          state_d = HOLD;
          t_load  = 1'b1;
          t_value = CLOSE_RELOAD;
        end else if (t_zero) begin
          state_d   = CLOSED;
          timeout_d = 1'b1;
        end else begin
          t_dec = 1'b1;
        end
      end
      HOLD: begin
        // Extra entries here are expected (cars queueing) and do not re-arm.
        if (t_zero) begin
          state_d = CLOSED;
        end else begin
          t_dec = 1'b1;
        end
      end
      default: begin
        state_d = CLOSED;
      end
    endcase
  end

  // Error detection and sticky flag update. A clear and a fresh error in the
  // same cycle leave the fresh bit set while the other bits clear.
  always_comb begin
    err_new            = '0;
    err_new[TAILGATE]  = is_entry && (state_q == CLOSED);
    err_new[OVERFLOW]  = is_entry && (cnt == 3'd7);
    err_new[UNDERFLOW] = is_exit  && (cnt == 3'd0);
    err_d = (err_clr ? 3'b000 : err_q) | err_new;
  end

  // Registered gate command and lot-full flag.
  always_comb begin
    gate_open_d = (state_d != CLOSED);
    full_d      = (int'(cnt) >= CAPACITY);
  end

  // State and output registers; reset drops the gate on the next edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= CLOSED;
      gate_open_q <= 1'b0;
      full_q      <= 1'b0;
      deny_q      <= 1'b0;
      timeout_q   <= 1'b0;
      err_q       <= 3'b000;
    end else begin
      state_q     <= state_d;
      gate_open_q <= gate_open_d;
      full_q      <= full_d;
      deny_q      <= deny_d;
      timeout_q   <= timeout_d;
      err_q       <= err_d;
    end
  end

  assign gate_open = gate_open_q;
  assign full      = full_q;
  assign deny      = deny_q;
  assign timeout   = timeout_q;
  assign err_flags = err_q;

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// tb_parking_gate_ctrl
// Directed bench for parking_gate_ctrl. Two instances share the stimulus:
// dut7 uses the default CAPACITY of 7, dut5 uses CAPACITY 5.
module tb_parking_gate_ctrl;

  localparam int OT = 1000;
  localparam int CD = 200;

  logic       clk;
  logic       rst;
  logic       req_in;
  logic [1:0] dtc;
  logic [2:0] cnt;
  logic       err_clr;

  logic       gate_open7, full7, deny7, timeout7;
  logic [2:0] err7;
  logic       gate_open5, full5, deny5, timeout5;
  logic [2:0] err5;

  int checks;
  int errors;

  parking_gate_ctrl #(.CAPACITY(7), .OPEN_TIMEOUT(OT), .CLOSE_DELAY(CD)) dut7 (
    .clk       (clk),
    .rst       (rst),
    .req_in    (req_in),
    .dtc       (dtc),
    .cnt       (cnt),
    .err_clr   (err_clr),
    .gate_open (gate_open7),
    .full      (full7),
    .deny      (deny7),
    .timeout   (timeout7),
    .err_flags (err7)
  );

  parking_gate_ctrl #(.CAPACITY(5), .OPEN_TIMEOUT(OT), .CLOSE_DELAY(CD)) dut5 (
    .clk       (clk),
    .rst       (rst),
    .req_in    (req_in),
    .dtc       (dtc),
    .cnt       (cnt),
    .err_clr   (err_clr),
    .gate_open (gate_open5),
    .full      (full5),
    .deny      (deny5),
    .timeout   (timeout5),
    .err_flags (err5)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive every DUT input at once.
  task automatic applyStimulus(input logic r, input logic rq, input logic [1:0] d,
                               input logic [2:0] c, input logic ec);
    rst     = r;
    req_in  = rq;
    dtc     = d;
    cnt     = c;
    err_clr = ec;
  endtask

  // Advance n rising edges, then settle 1 ns past the edge for sampling.
  task automatic stepCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One comparison: count it, and on a miss count and report it.
  task automatic checkOutput(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
      $error("[TB] %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;

    // Power-up reset.
    applyStimulus(1'b1, 1'b0, 2'b00, 3'd2, 1'b0);
    stepCycles(3);
    checkOutput("reset_gate", {2'b0, gate_open7}, 3'b000);
    checkOutput("reset_err", err7, 3'b000);
    checkOutput("reset_full", {2'b0, full7}, 3'b000);
    checkOutput("reset_deny_timeout", {1'b0, deny7, timeout7}, 3'b000);
    applyStimulus(1'b0, 1'b0, 2'b00, 3'd2, 1'b0);
    stepCycles(1);

    // Request with no entry: open exactly OT cycles, then a timeout pulse.
    applyStimulus(1'b0, 1'b1, 2'b00, 3'd2, 1'b0);
    stepCycles(1);
    applyStimulus(1'b0, 1'b0, 2'b00, 3'd2, 1'b0);
    checkOutput("to_open_first", {2'b0, gate_open7}, 3'b001);
    stepCycles(OT - 1);
    checkOutput("to_open_last", {1'b0, gate_open7, timeout7}, 3'b010);
    stepCycles(1);
    checkOutput("to_closed_pulse", {1'b0, gate_open7, timeout7}, 3'b001);
    stepCycles(1);
    checkOutput("to_pulse_end", {1'b0, gate_open7, timeout7}, 3'b000);

    // Entry on the 5th open cycle: hold for CD cycles, no timeout.
    applyStimulus(1'b0, 1'b1, 2'b00, 3'd2, 1'b0);
    stepCycles(1);
    applyStimulus(1'b0, 1'b0, 2'b00, 3'd2, 1'b0);
    stepCycles(4);
    applyStimulus(1'b0, 1'b0, 2'b01, 3'd2, 1'b0);
    stepCycles(1);
    applyStimulus(1'b0, 1'b0, 2'b00, 3'd3, 1'b0);
    checkOutput("hold_open", {2'b0, gate_open7}, 3'b001);
    stepCycles(CD - 1);
    checkOutput("hold_last", {1'b0, gate_open7, timeout7}, 3'b010);
    stepCycles(1);
    checkOutput("hold_closed", {1'b0, gate_open7, timeout7}, 3'b000);
    checkOutput("hold_no_err", err7, 3'b000);

    // Entry on the very cycle the open timer is zero: entry wins.
    applyStimulus(1'b0, 1'b1, 2'b00, 3'd3, 1'b0);
    stepCycles(1);
    applyStimulus(1'b0, 1'b0, 2'b00, 3'd3, 1'b0);
    stepCycles(OT - 1);
    applyStimulus(1'b0, 1'b0, 2'b01, 3'd3, 1'b0);
    stepCycles(1);
    applyStimulus(1'b0, 1'b0, 2'b00, 3'd4, 1'b0);
    checkOutput("race_hold", {1'b0, gate_open7, timeout7}, 3'b010);
    stepCycles(CD);
    checkOutput("race_closed", {1'b0, gate_open7, timeout7}, 3'b000);

    // Reserved code 10: no state change, no error, in CLOSED and in OPEN.
    applyStimulus(1'b0, 1'b0, 2'b10, 3'd0, 1'b0);
    stepCycles(1);
    checkOutput("rsv_closed", {err7[2:1], gate_open7}, 3'b000);
    checkOutput("rsv_closed_err", err7, 3'b000);
    applyStimulus(1'b0, 1'b1, 2'b00, 3'd0, 1'b0);
    stepCycles(1);
    applyStimulus(1'b0, 1'b0, 2'b10, 3'd7, 1'b0);
    stepCycles(1);
    checkOutput("rsv_open", {2'b0, gate_open7}, 3'b001);
    checkOutput("rsv_open_err", err7, 3'b000);

    // Reset held 3 cycles while open; cnt=7 must not set full under reset.
    applyStimulus(1'b1, 1'b0, 2'b00, 3'd7, 1'b0);
    stepCycles(1);
    checkOutput("rst_gate_drop", {2'b0, gate_open7}, 3'b000);
    stepCycles(2);
    checkOutput("rst_hold", {full7, gate_open7, timeout7}, 3'b000);
    checkOutput("rst_hold_err", err7, 3'b000);

    // Lot full at CAPACITY=7: three denied request cycles.
    applyStimulus(1'b0, 1'b0, 2'b00, 3'd7, 1'b0);
    stepCycles(1);
    checkOutput("full7_set", {1'b0, full7, full5}, 3'b011);
    applyStimulus(1'b0, 1'b1, 2'b00, 3'd7, 1'b0);
    for (int i = 0; i < 3; i++) begin
      stepCycles(1);
      checkOutput($sformatf("deny7_%0d", i), {1'b0, deny7, gate_open7}, 3'b010);
    end
    applyStimulus(1'b0, 1'b0, 2'b00, 3'd7, 1'b0);
    stepCycles(1);
    checkOutput("deny7_end", {1'b0, deny7, gate_open7}, 3'b000);

    // CAPACITY=5 instance full at cnt=5 while the default one is not.
    applyStimulus(1'b0, 1'b0, 2'b00, 3'd5, 1'b0);
    stepCycles(1);
    checkOutput("full5_only", {1'b0, full7, full5}, 3'b001);
    applyStimulus(1'b0, 1'b1, 2'b00, 3'd5, 1'b0);
    for (int i = 0; i < 3; i++) begin
      stepCycles(1);
      checkOutput($sformatf("deny5_%0d", i), {1'b0, deny5, gate_open5}, 3'b010);
    end
    checkOutput("cap7_opened", {1'b0, deny7, gate_open7}, 3'b001);
    applyStimulus(1'b1, 1'b0, 2'b00, 3'd5, 1'b0);
    stepCycles(1);
    applyStimulus(1'b0, 1'b0, 2'b00, 3'd5, 1'b0);
    stepCycles(1);

    // Error flags: tailgate + overflow, clear, then clear racing an underflow.
    applyStimulus(1'b0, 1'b0, 2'b01, 3'd7, 1'b0);
    stepCycles(1);
    checkOutput("err_tg_ovf", err7, 3'b110);
    checkOutput("err_tg_gate", {2'b0, gate_open7}, 3'b000);
    applyStimulus(1'b0, 1'b0, 2'b00, 3'd7, 1'b1);
    stepCycles(1);
    checkOutput("err_clear", err7, 3'b000);
    applyStimulus(1'b0, 1'b0, 2'b01, 3'd7, 1'b0);
    stepCycles(1);
    checkOutput("err_reset_again", err7, 3'b110);
    applyStimulus(1'b0, 1'b0, 2'b11, 3'd0, 1'b1);
    stepCycles(1);
    checkOutput("err_clr_vs_udf", err7, 3'b001);
    checkOutput("err_clr_vs_udf5", err5, 3'b001);
    applyStimulus(1'b0, 1'b0, 2'b00, 3'd0, 1'b0);
    stepCycles(1);
    checkOutput("err_sticky", err7, 3'b001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
